uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART byte transmitter between NUM_REQ requesters.
//   - Requesters include the echo path, the LED/status reporter and test-pattern sources.
//   - Round-robin arbitration; each requester uses a valid/ready byte interface.
//   - Sequences the transmitter over a start/busy handshake: one byte per grant.
//   - Sits between the requesters and the 8N1 serialiser on user_clock (40 MHz).
// PARAMETERS
//   NUM_REQ   4   number of requesters, 2..8
//   DATA_W    8   byte width on every data port
// PORTS
//   user_clock  in   1                  system clock, 40 MHz; all logic on rising edge
//   rst         in   1                  synchronous, active-low reset
//   req_valid   in   NUM_REQ            per-requester byte available
//   req_data    in   NUM_REQ*DATA_W     requester i byte at [i*DATA_W +: DATA_W]
//   req_last    in   NUM_REQ            byte is last of packet (used only with lock feature)
//   req_ready   out  NUM_REQ            one-hot accept; byte transfers when valid&ready
//   tx_start    out  1                  one-cycle pulse: serialiser loads tx_data
//   tx_data     out  DATA_W             byte to serialiser, stable from tx_start to busy fall
//   tx_busy     in   1                  serialiser shifting (start, data, stop bits)
//   grant_id    out  $clog2(NUM_REQ)    index of current/last granted requester
//   grant_valid out  1                  high while a granted byte is in flight
// BEHAVIOUR
//   Reset (rst==0 at an edge):
//     - state=IDLE, rr_ptr=0, tx_start=0, tx_data=0, grant_id=0, grant_valid=0.
//     - An in-flight serialiser byte is abandoned; the arbiter does not track it.
//   States:
//   - IDLE: req_ready is combinational. It is one-hot at winner w when tx_busy==0 and any req_valid.
//     w = first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
//     On that edge: tx_data<=req_data[w], grant_id<=w, grant_valid<=1, ->ISSUE.
//   - ISSUE: tx_start=1 for exactly this cycle. ->WAIT_BUSY.
//   - WAIT_BUSY: hold until tx_busy==1, then ->WAIT_DONE. No timeout.
//   - WAIT_DONE: hold until tx_busy==0. On exit: grant_valid<=0, rr_ptr<=(grant_id+1)%NUM_REQ, ->IDLE.
//   Latency: valid to tx_start is 1 cycle when idle. Back-to-back min spacing is serialiser frame + 3 cycles.
//   req_ready is low in every state except IDLE; at most one bit is set.
//   Requesters must hold valid/data until ready. If valid drops before ready, nothing transfers and no error is flagged.
//   tx_busy==1 while in IDLE (e.g. after reset): no grant until it falls.
//   Simultaneous valids: rr_ptr decides. A requester that just won has lowest priority next.
//   rr_ptr wraps NUM_REQ-1 -> 0.
//   tx_data is unchanged after WAIT_DONE until the next grant.
// CONFIGURATION
//   UART_ARB_PKT_LOCK_EN defined:
//     - Accepted byte from w with req_last==0 locks the arbiter: rr_ptr<=w, and only w is eligible in IDLE.
//     - The lock clears when w's byte with req_last==1 completes; rr_ptr then advances to w+1.
//     - Reset clears the lock.
//   Not defined: req_last is ignored and the grant rotates after every byte.
// STRUCTURE
//   uart_pkg (shared):
//     - localparam state encodings IDLE=2'd0, ISSUE=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3.
//     - UART_DATA_W=8.
//     - Function clog2 for index widths.
//   Sub-module uart_rr_pick: combinational rotate/priority-encode/rotate-back.
//     - Inputs: valid vector, rr_ptr. Outputs: winner index and any_valid.
//     - Reusable for the RX-side dispatcher.
//   Top holds the FSM, the data register, rr_ptr and the lock register.
// TESTING
//   Serialiser model: tx_busy rises 1 cycle after tx_start and stays high 10*344 cycles. NUM_REQ=4.
//   1. Reset, req_valid=4'b0001, data0=8'h41 -> req_ready=4'b0001 that cycle; next cycle tx_start=1, tx_data=8'h41, grant_id=0.
//   2. All four valid, held -> grant order 0,1,2,3,0; each tx_start only after previous tx_busy fall.
//   3. tx_busy forced high at reset release, req_valid=4'b0100 -> req_ready stays 0 until busy falls, then grant 2.
//   4. rst=0 in WAIT_DONE -> next cycle grant_valid=0, tx_start=0; after release with valid 4'b1000, grant 3 (rr_ptr=0 scan).
//   5. valid1 drops before its grant while valid3 held -> only 3 granted, req_ready[1] never high.
//   6. With UART_ARB_PKT_LOCK_EN: req0 sends 3 bytes (last on 3rd), req1 valid throughout -> 0,0,0 then 1. Without: 0,1,0,1,0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: arbiter FSM states,
// the default byte width and an index-width helper usable in parameter lists.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } uart_arb_state_t;

    // Ceiling log2, evaluated at elaboration time for port and index widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of i_valid at or after
// i_rr_ptr, wrapping modulo NUM_REQ. Shared by the TX arbiter and the RX dispatcher.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any_valid
);

    logic [2*NUM_REQ-1:0] w_double;
    logic [NUM_REQ-1:0]   w_rotated;
    logic [IDX_W-1:0]     w_offset;
    logic                 w_found;
    logic [IDX_W:0]       w_sum;

    // Rotating the doubled vector puts rr_ptr at bit 0, so a plain lowest-bit
    // priority encode yields the offset from the pointer.
    assign w_double  = {i_valid, i_valid} >> i_rr_ptr;
    assign w_rotated = w_double[NUM_REQ-1:0];

    always_comb begin
        w_offset = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_rotated[i]) begin
                w_offset = IDX_W'(i);
                w_found  = 1'b1;
            end
        end
    end

    assign w_sum       = {1'b0, i_rr_ptr} + {1'b0, w_offset};
    assign o_winner    = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                                                         : w_sum[IDX_W-1:0];
    assign o_any_valid = |i_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte serialiser between NUM_REQ requesters.
// Define UART_ARB_PKT_LOCK_EN to hold the grant on one requester until its req_last byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W
) (
    input  logic                      user_clock,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [clog2(NUM_REQ)-1:0] grant_id,
    output logic                      grant_valid
);

    localparam int IDX_W = clog2(NUM_REQ);

    uart_arb_state_t  r_state;
    logic [IDX_W-1:0] r_rr_ptr;

    logic [NUM_REQ-1:0] w_eligible;
    logic [IDX_W-1:0]   w_winner;
    logic               w_any_valid;
    logic               w_accept;
    logic [IDX_W-1:0]   w_next_ptr;

`ifdef UART_ARB_PKT_LOCK_EN
    logic r_locked;
    logic r_last_byte;

    // While locked, rr_ptr holds the owner, so masking to that bit keeps the grant there.
    assign w_eligible = r_locked ? (req_valid & (NUM_REQ'(1) << r_rr_ptr)) : req_valid;
`else
    logic w_unused_last;

    assign w_unused_last = ^req_last;
    assign w_eligible    = req_valid;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_valid     (w_eligible),
        .i_rr_ptr    (r_rr_ptr),
        .o_winner    (w_winner),
        .o_any_valid (w_any_valid)
    );

    assign w_accept   = (r_state == IDLE) && !tx_busy && w_any_valid;
    assign w_next_ptr = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready = NUM_REQ'(1) << w_winner;
        end
    end

    // One byte per grant: latch it, pulse start, then follow the serialiser busy flag.
    always_ff @(posedge user_clock) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
            r_locked    <= 1'b0;
            r_last_byte <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (w_accept) begin
                        tx_data     <= req_data[w_winner*DATA_W +: DATA_W];
                        grant_id    <= w_winner;
                        grant_valid <= 1'b1;
                        tx_start    <= 1'b1;
                        r_state     <= ISSUE;
`ifdef UART_ARB_PKT_LOCK_EN
                        r_last_byte <= req_last[w_winner];
                        if (!req_last[w_winner]) begin
                            r_locked <= 1'b1;
                            r_rr_ptr <= w_winner;
                        end
`endif
                    end
                end
                ISSUE: begin
                    tx_start <= 1'b0;
                    r_state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        grant_valid <= 1'b0;
                        r_state     <= IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
                        if (r_last_byte) begin
                            r_locked <= 1'b0;
                            r_rr_ptr <= w_next_ptr;
                        end
`else
                        r_rr_ptr <= w_next_ptr;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester sources, a serialiser
// busy model and a tx_start monitor checking grants against hand-computed order.
module tb_uart_tx_arbiter;

    localparam int FRAME_CYCLES = 10 * 344;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } grant_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqLast;
    logic [3:0]  reqReady;
    logic        txStart;
    logic [7:0]  txData;
    logic        txBusy;
    logic [1:0]  grantId;
    logic        grantValid;

    logic        modelBusy = 1'b0;
    int          modelCount = 0;
    logic        forceBusy;
    logic        watchReady1;
    logic        ready1Seen;
    logic        onehotErr;

    logic [7:0]  srcData [4][$];
    logic        srcLast [4][$];
    grant_t      expQ [$];

    int          errorCount = 0;
    int          checkCount = 0;

    uart_tx_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8)
    ) dut (
        .user_clock  (clk),
        .rst         (rst),
        .req_valid   (reqValid),
        .req_data    (reqData),
        .req_last    (reqLast),
        .req_ready   (reqReady),
        .tx_start    (txStart),
        .tx_data     (txData),
        .tx_busy     (txBusy),
        .grant_id    (grantId),
        .grant_valid (grantValid)
    );

    always #5 clk = ~clk;

    assign txBusy = modelBusy | forceBusy;

    // Serialiser: busy rises the cycle after tx_start and holds for one 8N1 frame.
    always @(posedge clk) begin
        if (txStart) begin
            modelBusy  <= 1'b1;
            modelCount <= FRAME_CYCLES - 1;
        end else if (modelBusy) begin
            if (modelCount == 0) begin
                modelBusy <= 1'b0;
            end else begin
                modelCount <= modelCount - 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int req, input logic [7:0] data, input logic last);
        srcData[req].push_back(data);
        srcLast[req].push_back(last);
    endtask

    task automatic expectGrant(input logic [1:0] id, input logic [7:0] data);
        grant_t g;
        g.id   = id;
        g.data = data;
        expQ.push_back(g);
    endtask

    task automatic clearSources();
        for (int i = 0; i < 4; i++) begin
            srcData[i].delete();
            srcLast[i].delete();
        end
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearSources();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_tx_start", 32'(txStart), 32'd0);
        checkOutput("reset_tx_data", 32'(txData), 32'd0);
        checkOutput("reset_grant_id", 32'(grantId), 32'd0);
        checkOutput("reset_grant_valid", 32'(grantValid), 32'd0);
        rst = 1'b1;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || grantValid) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= budget) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL %s: timeout after %0d cycles, %0d grants outstanding", name, n, expQ.size());
        end
    endtask

    task automatic waitIssued(input string name, input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= budget) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL %s: timeout after %0d cycles waiting for tx_start", name, n);
        end
    endtask

    // Requester sources present their queue head until the handshake, then pop.
    initial begin
        logic [3:0] hs;
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (srcData[i].size() > 0) begin
                    reqValid[i]         = 1'b1;
                    reqData[i*8 +: 8]   = srcData[i][0];
                    reqLast[i]          = srcLast[i][0];
                end else begin
                    reqValid[i]         = 1'b0;
                    reqData[i*8 +: 8]   = 8'h00;
                    reqLast[i]          = 1'b0;
                end
            end
            #3;
            hs = reqValid & reqReady;
            if (!$onehot0(reqReady)) onehotErr = 1'b1;
            if (watchReady1 && reqReady[1]) ready1Seen = 1'b1;
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (hs[i] && srcData[i].size() > 0) begin
                    void'(srcData[i].pop_front());
                    void'(srcLast[i].pop_front());
                end
            end
        end
    end

    // Monitor: every tx_start must match the next expected grant and follow a busy fall.
    initial begin
        grant_t g;
        forever begin
            @(negedge clk);
            if (txStart) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpected_grant: got id %0d data 0x%0h, expected no grant", grantId, txData);
                end else begin
                    g = expQ.pop_front();
                    checkOutput("grant_id", 32'(grantId), 32'(g.id));
                    checkOutput("grant_data", 32'(txData), 32'(g.data));
                    checkOutput("start_while_idle_busy", 32'(txBusy), 32'd0);
                end
            end
        end
    end

    initial begin
        #(90000 * 10);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errorCount + 1, checkCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        forceBusy   = 1'b0;
        watchReady1 = 1'b0;
        ready1Seen  = 1'b0;
        onehotErr   = 1'b0;

        // Single requester, idle arbiter: ready the same cycle, start the next.
        applyReset();
        applyStimulus(0, 8'h41, 1'b1);
        expectGrant(2'd0, 8'h41);
        @(negedge clk);
        #1;
        checkOutput("t1_req_ready", 32'(reqReady), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("t1_tx_start", 32'(txStart), 32'd1);
        checkOutput("t1_tx_data", 32'(txData), 32'h41);
        checkOutput("t1_grant_id", 32'(grantId), 32'd0);
        waitDrain("t1_drain", FRAME_CYCLES + 50);
        checkOutput("t1_tx_data_held", 32'(txData), 32'h41);

        // All four requesters held valid: strict rotation 0,1,2,3,0.
        applyReset();
        applyStimulus(0, 8'h10, 1'b1);
        applyStimulus(0, 8'h14, 1'b1);
        applyStimulus(1, 8'h11, 1'b1);
        applyStimulus(2, 8'h12, 1'b1);
        applyStimulus(3, 8'h13, 1'b1);
        expectGrant(2'd0, 8'h10);
        expectGrant(2'd1, 8'h11);
        expectGrant(2'd2, 8'h12);
        expectGrant(2'd3, 8'h13);
        expectGrant(2'd0, 8'h14);
        waitDrain("t2_drain", 6 * FRAME_CYCLES);

        // Serialiser busy at reset release blocks the grant until it falls.
        forceBusy = 1'b1;
        applyReset();
        applyStimulus(2, 8'h62, 1'b1);
        expectGrant(2'd2, 8'h62);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("t3_ready_while_busy", 32'(reqReady), 32'h0);
        end
        @(posedge clk);
        #1;
        forceBusy = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t3_ready_after_busy", 32'(reqReady), 32'h4);
        waitIssued("t3_issue", 50);

        // Reset in WAIT_DONE abandons the byte; requester 3 wins once busy falls.
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t4_grant_valid_cleared", 32'(grantValid), 32'd0);
        checkOutput("t4_tx_start_cleared", 32'(txStart), 32'd0);
        rst = 1'b1;
        applyStimulus(3, 8'h73, 1'b1);
        expectGrant(2'd3, 8'h73);
        waitIssued("t4_issue", FRAME_CYCLES + 50);

        // Requester 1 withdraws before being served; only requester 3 is granted.
        repeat (20) @(posedge clk);
        #1;
        watchReady1 = 1'b1;
        applyStimulus(1, 8'h51, 1'b1);
        applyStimulus(3, 8'h53, 1'b1);
        expectGrant(2'd3, 8'h53);
        repeat (100) @(posedge clk);
        #1;
        srcData[1].delete();
        srcLast[1].delete();
        waitDrain("t5_drain", 3 * FRAME_CYCLES);
        watchReady1 = 1'b0;
        checkOutput("t5_ready1_never", 32'(ready1Seen), 32'd0);

        // Three-byte packet from requester 0 against a continuously valid requester 1.
        applyStimulus(0, 8'hA0, 1'b0);
        applyStimulus(0, 8'hA1, 1'b0);
        applyStimulus(0, 8'hA2, 1'b1);
        applyStimulus(1, 8'hB0, 1'b1);
        applyStimulus(1, 8'hB1, 1'b1);
`ifdef UART_ARB_PKT_LOCK_EN
        expectGrant(2'd0, 8'hA0);
        expectGrant(2'd0, 8'hA1);
        expectGrant(2'd0, 8'hA2);
        expectGrant(2'd1, 8'hB0);
        expectGrant(2'd1, 8'hB1);
`else
        expectGrant(2'd0, 8'hA0);
        expectGrant(2'd1, 8'hB0);
        expectGrant(2'd0, 8'hA1);
        expectGrant(2'd1, 8'hB1);
        expectGrant(2'd0, 8'hA2);
`endif
        waitDrain("t6_drain", 6 * FRAME_CYCLES);

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        checkOutput("ready_onehot", 32'(onehotErr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
